// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I opcode encodings and fetch-stage types.
package rv32i_types;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0060;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;
  typedef enum logic [1:0] {IDLE, BUSY, HELD, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load/clear and decode field slicing.
module if_id_reg
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instruction,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid <= 1'b0;
      pc <= '0;
      instruction <= '0;
    end else if (load) begin
      valid <= 1'b1;
      pc <= load_pc;
      instruction <= load_instruction;
    end else if (clear) valid <= 1'b0;
  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];
  assign rd = instruction[11:7];
  assign rs1 = instruction[19:15];
  assign rs2 = instruction[24:20];
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I fetch FSM with held-address imem handshake, one-entry skid
// buffer for decode stalls and wrong-path squash on EX redirects.
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instruction,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2
);
  fetch_state_t state, state_n;
  logic [31:0] pc, pc_n, req_addr, req_n, skid_pc, skid_instruction, rpc;
  logic accept, id_load, skid_load;
  assign rpc = redirect_pc & ~32'd3;
  assign accept = !id_valid || !stall;
  assign imem_read = (state == BUSY) || (state == DRAIN);
  assign imem_address = req_addr;
  always_comb begin
    state_n = state;
    pc_n = pc;
    req_n = req_addr;
    id_load = 1'b0;
    skid_load = 1'b0;
    case (state)
      IDLE: begin
        state_n = BUSY;
        pc_n = redirect ? rpc : pc;
        req_n = pc_n;
      end
      BUSY:
        if (imem_resp) begin
          pc_n = redirect ? rpc : pc + 32'd4;
          req_n = pc_n;
          id_load = !redirect && accept;
          skid_load = !redirect && !accept;
          state_n = (redirect || accept) ? BUSY : HELD;
        end else if (redirect) begin
          pc_n = rpc;
          state_n = DRAIN;
        end
      HELD:
        if (redirect) begin
          pc_n = rpc;
          req_n = rpc;
          state_n = BUSY;
        end else if (!stall) begin
          id_load = 1'b1;
          req_n = pc;
          state_n = BUSY;
        end
      DRAIN: begin
        // the wrong-path request must complete at its original address
        pc_n = redirect ? rpc : pc;
        if (imem_resp) begin
          req_n = pc_n;
          state_n = BUSY;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      req_addr <= '0;
      skid_pc <= '0;
      skid_instruction <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      req_addr <= req_n;
      if (skid_load) begin
        skid_pc <= req_addr;
        skid_instruction <= imem_rdata;
      end
    end
  if_id_reg u_if_id (
    .clk(clk),
    .rst(rst),
    .load(id_load),
    .clear(redirect || (id_valid && !stall)),
    .load_pc(state == HELD ? skid_pc : req_addr),
    .load_instruction(state == HELD ? skid_instruction : imem_rdata),
    .valid(id_valid),
    .pc(id_pc),
    .instruction(id_instruction),
    .opcode(id_opcode),
    .funct3(id_funct3),
    .funct7(id_funct7),
    .rd(id_rd),
    .rs1(id_rs1),
    .rs2(id_rs2)
  );
endmodule
